bus_arbiter: RTL and testbench

- Shares the single daisy-chained 16-bit register bus (addr/wdata/rdata/rw/valid) between two independent requesters, A and B.
- Example requesters: the host bridge and an on-chip sweeper/DMA.
- Issues transactions into the head of the core chain (e.g. BRAM cores) and receives them back at the tail.
- The chain is in-order with arbitrary fixed latency; a tag FIFO routes each returning response to the requester that issued it.

---
 rtl/bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-requester arbiter for the daisy-chained register bus. Round-robin grant on
// contention; a tag FIFO routes each in-order response back to the requester that issued it.
module bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // requester A
    input  logic [15:0]          a_addr_i,
    input  logic [15:0]          a_wdata_i,
    input  logic                 a_rw_i,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    output logic [15:0]          a_rdata_o,
    output logic                 a_rvalid_o,
    // requester B
    input  logic [15:0]          b_addr_i,
    input  logic [15:0]          b_wdata_i,
    input  logic                 b_rw_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    output logic [15:0]          b_rdata_o,
    output logic                 b_rvalid_o,
    // chain head
    output logic [15:0]          addr_o,
    output logic [15:0]          wdata_o,
    output logic [15:0]          rdata_o,
    output logic                 rw_o,
    output logic                 valid_o,
    // chain tail
    input  logic [15:0]          addr_i,
    input  logic [15:0]          wdata_i,
    input  logic [15:0]          rdata_i,
    input  logic                 rw_i,
    input  logic                 valid_i,
    // status
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 err_o
);

    localparam int unsigned           PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0]  MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    owner_t               last_grant;
    owner_t               tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;

    logic   space;
    logic   grant_a;
    logic   grant_b;
    logic   push;
    logic   pop;
    logic   fifo_empty;
    owner_t grant_owner;
    owner_t pop_owner;

    // Tail address/data/rw are debug-only; the chain does its own decoding.
    logic unused_tail;
    assign unused_tail = ^{addr_i, wdata_i, rw_i};

    // Space is judged on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        space   = (count < MAX_CNT);
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (space) begin
            if (a_valid_i && b_valid_i) begin
                if (last_grant == OWNER_B) grant_a = 1'b1;
                else                       grant_b = 1'b1;
            end else begin
                grant_a = a_valid_i;
                grant_b = b_valid_i;
            end
        end
        push        = grant_a | grant_b;
        grant_owner = grant_b ? OWNER_B : OWNER_A;
        fifo_empty  = (count == '0);
        pop         = valid_i && !fifo_empty;
        pop_owner   = tag_mem[rd_ptr];
    end

    assign a_ready_o     = grant_a;
    assign b_ready_o     = grant_b;
    assign rdata_o       = '0;
    assign outstanding_o = count;

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant_owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWNER_B;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_o    <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            rw_o       <= 1'b0;
            a_rvalid_o <= 1'b0;
            a_rdata_o  <= '0;
            b_rvalid_o <= 1'b0;
            b_rdata_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            valid_o <= push;
            if (push) begin
                addr_o     <= grant_b ? b_addr_i  : a_addr_i;
                wdata_o    <= grant_b ? b_wdata_i : a_wdata_i;
                rw_o       <= grant_b ? b_rw_i    : a_rw_i;
                last_grant <= grant_owner;
                wr_ptr     <= wr_ptr + 1'b1;
            end

            a_rvalid_o <= 1'b0;
            b_rvalid_o <= 1'b0;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (pop_owner == OWNER_A) begin
                    a_rvalid_o <= 1'b1;
                    a_rdata_o  <= rdata_i;
                end else begin
                    b_rvalid_o <= 1'b1;
                    b_rdata_o  <= rdata_i;
                end
            end

            if (valid_i && fifo_empty) err_o <= 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a vector table for grant/issue/return behaviour,
// then hand-written sequences for backpressure, push/pop overlap and reset mid-flight.
module tb_bus_arbiter;

    localparam logic [15:0] AA = 16'h00A1;
    localparam logic [15:0] AW = 16'h1111;
    localparam logic [15:0] BA = 16'h00B2;
    localparam logic [15:0] BW = 16'h2222;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
    logic        a_rw_i, a_valid_i, b_rw_i, b_valid_i;
    logic        a_ready_o, a_rvalid_o, b_ready_o, b_rvalid_o;
    logic [15:0] a_rdata_o, b_rdata_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;
    logic [3:0]  outstanding_o;
    logic        err_o;

    int unsigned passed = 0;
    int unsigned total  = 0;

    bus_arbiter #(.MAX_OUTSTANDING(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rw_i(a_rw_i), .a_valid_i(a_valid_i),
        .a_ready_o(a_ready_o), .a_rdata_o(a_rdata_o), .a_rvalid_o(a_rvalid_o),
        .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_rw_i(b_rw_i), .b_valid_i(b_valid_i),
        .b_ready_o(b_ready_o), .b_rdata_o(b_rdata_o), .b_rvalid_o(b_rvalid_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [15:0] aaddr;
        logic [15:0] awd;
        logic        bv;
        logic        tv;
        logic [15:0] trd;
        logic        ea_rdy;
        logic        eb_rdy;
        logic        ev;
        logic [15:0] eaddr;
        logic [15:0] ewd;
        logic        erw;
        logic        ea_rv;
        logic        eb_rv;
        logic [15:0] ea_rd;
        logic [15:0] eb_rd;
        logic [3:0]  eout;
        logic        eerr;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mkv(
        input logic av, input logic [15:0] aaddr, input logic [15:0] awd,
        input logic bv, input logic tv, input logic [15:0] trd,
        input logic ea_rdy, input logic eb_rdy, input logic ev,
        input logic [15:0] eaddr, input logic [15:0] ewd, input logic erw,
        input logic ea_rv, input logic eb_rv, input logic [15:0] ea_rd, input logic [15:0] eb_rd,
        input logic [3:0] eout, input logic eerr);
        vec_t v;
        v.av = av; v.aaddr = aaddr; v.awd = awd; v.bv = bv; v.tv = tv; v.trd = trd;
        v.ea_rdy = ea_rdy; v.eb_rdy = eb_rdy; v.ev = ev; v.eaddr = eaddr; v.ewd = ewd;
        v.erw = erw; v.ea_rv = ea_rv; v.eb_rv = eb_rv; v.ea_rd = ea_rd; v.eb_rd = eb_rd;
        v.eout = eout; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_valid_i = 1'b0; b_valid_i = 1'b0; valid_i = 1'b0;
        a_addr_i = AA; a_wdata_i = AW; a_rw_i = 1'b0;
        b_addr_i = BA; b_wdata_i = BW; b_rw_i = 1'b1;
        addr_i = '0; wdata_i = '0; rw_i = 1'b0; rdata_i = '0;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk({tag, " rst valid_o"}, 32'(valid_o), 32'd0);
        chk({tag, " rst addr_o"}, 32'(addr_o), 32'd0);
        chk({tag, " rst outstanding"}, 32'(outstanding_o), 32'd0);
        chk({tag, " rst err"}, 32'(err_o), 32'd0);
        chk({tag, " rst a_rvalid"}, 32'(a_rvalid_o), 32'd0);
        chk({tag, " rst b_rdata"}, 32'(b_rdata_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int unsigned nacc;

        // Contention from reset (A wins first), returns A,B,..., idle, single read, orphan.
        tbl[0]  = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,16'h0,16'h0,0, 0,0,16'h0,16'h0,      0,0);
        tbl[1]  = mkv(1,AA,AW,     1,0,16'h0,    1,0,1,AA,AW,0,       0,0,16'h0,16'h0,      1,0);
        tbl[2]  = mkv(1,AA,AW,     1,0,16'h0,    0,1,1,BA,BW,1,       0,0,16'h0,16'h0,      2,0);
        tbl[3]  = mkv(1,AA,AW,     1,0,16'h0,    1,0,1,AA,AW,0,       0,0,16'h0,16'h0,      3,0);
        tbl[4]  = mkv(1,AA,AW,     1,0,16'h0,    0,1,1,BA,BW,1,       0,0,16'h0,16'h0,      4,0);
        tbl[5]  = mkv(1,AA,AW,     1,0,16'h0,    1,0,1,AA,AW,0,       0,0,16'h0,16'h0,      5,0);
        tbl[6]  = mkv(1,AA,AW,     1,0,16'h0,    0,1,1,BA,BW,1,       0,0,16'h0,16'h0,      6,0);
        tbl[7]  = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,BA,BW,1,       0,0,16'h0,16'h0,      6,0);
        tbl[8]  = mkv(0,AA,AW,     0,1,16'h5001, 0,0,0,BA,BW,1,       1,0,16'h5001,16'h0,   5,0);
        tbl[9]  = mkv(0,AA,AW,     0,1,16'h5002, 0,0,0,BA,BW,1,       0,1,16'h5001,16'h5002,4,0);
        tbl[10] = mkv(0,AA,AW,     0,1,16'h5003, 0,0,0,BA,BW,1,       1,0,16'h5003,16'h5002,3,0);
        tbl[11] = mkv(0,AA,AW,     0,1,16'h5004, 0,0,0,BA,BW,1,       0,1,16'h5003,16'h5004,2,0);
        tbl[12] = mkv(0,AA,AW,     0,1,16'h5005, 0,0,0,BA,BW,1,       1,0,16'h5005,16'h5004,1,0);
        tbl[13] = mkv(0,AA,AW,     0,1,16'h5006, 0,0,0,BA,BW,1,       0,1,16'h5005,16'h5006,0,0);
        tbl[14] = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,BA,BW,1,       0,0,16'h5005,16'h5006,0,0);
        tbl[15] = mkv(1,16'h3,16'h0,0,0,16'h0,   1,0,1,16'h3,16'h0,0, 0,0,16'h5005,16'h5006,1,0);
        tbl[16] = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,16'h3,16'h0,0, 0,0,16'h5005,16'h5006,1,0);
        tbl[17] = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,16'h3,16'h0,0, 0,0,16'h5005,16'h5006,1,0);
        tbl[18] = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,16'h3,16'h0,0, 0,0,16'h5005,16'h5006,1,0);
        tbl[19] = mkv(0,AA,AW,     0,1,16'hBEEF, 0,0,0,16'h3,16'h0,0, 1,0,16'hBEEF,16'h5006,0,0);
        tbl[20] = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,16'h3,16'h0,0, 0,0,16'hBEEF,16'h5006,0,0);
        tbl[21] = mkv(0,AA,AW,     0,1,16'hDEAD, 0,0,0,16'h3,16'h0,0, 0,0,16'hBEEF,16'h5006,0,1);
        tbl[22] = mkv(0,AA,AW,     0,0,16'h0,    0,0,0,16'h3,16'h0,0, 0,0,16'hBEEF,16'h5006,0,1);

        do_reset("init");

        for (int i = 0; i < 23; i++) begin
            string p;
            p = $sformatf("v%0d", i);
            a_valid_i = tbl[i].av; a_addr_i = tbl[i].aaddr; a_wdata_i = tbl[i].awd; a_rw_i = 1'b0;
            b_valid_i = tbl[i].bv; b_addr_i = BA; b_wdata_i = BW; b_rw_i = 1'b1;
            valid_i = tbl[i].tv; rdata_i = tbl[i].trd;
            #2;
            chk({p, " a_ready"}, 32'(a_ready_o), 32'(tbl[i].ea_rdy));
            chk({p, " b_ready"}, 32'(b_ready_o), 32'(tbl[i].eb_rdy));
            tick();
            chk({p, " valid_o"}, 32'(valid_o), 32'(tbl[i].ev));
            chk({p, " addr_o"}, 32'(addr_o), 32'(tbl[i].eaddr));
            chk({p, " wdata_o"}, 32'(wdata_o), 32'(tbl[i].ewd));
            chk({p, " rw_o"}, 32'(rw_o), 32'(tbl[i].erw));
            chk({p, " rdata_o"}, 32'(rdata_o), 32'd0);
            chk({p, " a_rvalid"}, 32'(a_rvalid_o), 32'(tbl[i].ea_rv));
            chk({p, " b_rvalid"}, 32'(b_rvalid_o), 32'(tbl[i].eb_rv));
            chk({p, " a_rdata"}, 32'(a_rdata_o), 32'(tbl[i].ea_rd));
            chk({p, " b_rdata"}, 32'(b_rdata_o), 32'(tbl[i].eb_rd));
            chk({p, " outstanding"}, 32'(outstanding_o), 32'(tbl[i].eout));
            chk({p, " err"}, 32'(err_o), 32'(tbl[i].eerr));
        end

        // Backpressure: 10 cycles of A requests, only 8 fit.
        do_reset("bp");
        a_valid_i = 1'b1; a_addr_i = 16'h0100;
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (a_ready_o) nacc++;
            tick();
        end
        chk("bp accepted", nacc, 32'd8);
        chk("bp outstanding full", 32'(outstanding_o), 32'd8);
        #2;
        chk("bp ready when full", 32'(a_ready_o), 32'd0);
        valid_i = 1'b1; rdata_i = 16'h6001;
        #1;
        chk("bp no same-cycle credit", 32'(a_ready_o), 32'd0);
        tick();
        valid_i = 1'b0;
        chk("bp pop outstanding", 32'(outstanding_o), 32'd7);
        chk("bp pop a_rvalid", 32'(a_rvalid_o), 32'd1);
        chk("bp pop a_rdata", 32'(a_rdata_o), 32'h6001);
        #2;
        chk("bp ready after pop", 32'(a_ready_o), 32'd1);
        tick();
        a_valid_i = 1'b0;
        chk("bp refill outstanding", 32'(outstanding_o), 32'd8);
        chk("bp refill valid_o", 32'(valid_o), 32'd1);
        for (int k = 0; k < 8; k++) begin
            valid_i = 1'b1; rdata_i = 16'h6100 + 16'(k);
            tick();
            chk($sformatf("bp drain%0d a_rvalid", k), 32'(a_rvalid_o), 32'd1);
            chk($sformatf("bp drain%0d a_rdata", k), 32'(a_rdata_o), 32'h6100 + k);
            chk($sformatf("bp drain%0d b_rvalid", k), 32'(b_rvalid_o), 32'd0);
        end
        valid_i = 1'b0;
        chk("bp drained", 32'(outstanding_o), 32'd0);
        chk("bp no err", 32'(err_o), 32'd0);

        // Push and pop in the same cycle with three tags A,B,A in flight.
        do_reset("pp");
        a_valid_i = 1'b1; tick();
        a_valid_i = 1'b0; b_valid_i = 1'b1; tick();
        b_valid_i = 1'b0; a_valid_i = 1'b1; tick();
        a_valid_i = 1'b0;
        chk("pp outstanding 3", 32'(outstanding_o), 32'd3);
        b_valid_i = 1'b1; valid_i = 1'b1; rdata_i = 16'h7001;
        #2;
        chk("pp1 b_ready", 32'(b_ready_o), 32'd1);
        tick();
        chk("pp1 outstanding", 32'(outstanding_o), 32'd3);
        chk("pp1 a_rvalid", 32'(a_rvalid_o), 32'd1);
        chk("pp1 a_rdata", 32'(a_rdata_o), 32'h7001);
        chk("pp1 b_rvalid", 32'(b_rvalid_o), 32'd0);
        chk("pp1 issue rw", 32'(rw_o), 32'd1);
        b_valid_i = 1'b0; a_valid_i = 1'b1; rdata_i = 16'h7002;
        #2;
        chk("pp2 a_ready", 32'(a_ready_o), 32'd1);
        tick();
        a_valid_i = 1'b0;
        chk("pp2 outstanding", 32'(outstanding_o), 32'd3);
        chk("pp2 b_rvalid", 32'(b_rvalid_o), 32'd1);
        chk("pp2 b_rdata", 32'(b_rdata_o), 32'h7002);
        chk("pp2 a_rvalid", 32'(a_rvalid_o), 32'd0);
        rdata_i = 16'h7003; tick();
        chk("pp3 a_rvalid", 32'(a_rvalid_o), 32'd1);
        chk("pp3 a_rdata", 32'(a_rdata_o), 32'h7003);
        chk("pp3 outstanding", 32'(outstanding_o), 32'd2);
        rdata_i = 16'h7004; tick();
        chk("pp4 b_rvalid", 32'(b_rvalid_o), 32'd1);
        chk("pp4 b_rdata", 32'(b_rdata_o), 32'h7004);
        chk("pp4 outstanding", 32'(outstanding_o), 32'd1);
        rdata_i = 16'h7005; tick();
        valid_i = 1'b0;
        chk("pp5 a_rvalid", 32'(a_rvalid_o), 32'd1);
        chk("pp5 a_rdata", 32'(a_rdata_o), 32'h7005);
        chk("pp5 b_rvalid", 32'(b_rvalid_o), 32'd0);
        chk("pp5 outstanding", 32'(outstanding_o), 32'd0);

        // Reset with three reads in flight; their late responses become orphans.
        a_valid_i = 1'b1; a_addr_i = 16'h0042;
        tick(); tick(); tick();
        a_valid_i = 1'b0;
        chk("mr outstanding 3", 32'(outstanding_o), 32'd3);
        chk("mr valid_o before", 32'(valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr async valid_o", 32'(valid_o), 32'd0);
        chk("mr async addr_o", 32'(addr_o), 32'd0);
        chk("mr async outstanding", 32'(outstanding_o), 32'd0);
        chk("mr async a_rdata", 32'(a_rdata_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            valid_i = 1'b1; rdata_i = 16'h8001 + 16'(k);
            tick();
            chk($sformatf("mr late%0d a_rvalid", k), 32'(a_rvalid_o), 32'd0);
            chk($sformatf("mr late%0d b_rvalid", k), 32'(b_rvalid_o), 32'd0);
            chk($sformatf("mr late%0d err", k), 32'(err_o), 32'd1);
            chk($sformatf("mr late%0d outstanding", k), 32'(outstanding_o), 32'd0);
        end
        valid_i = 1'b0;
        tick(); tick();
        chk("mr err sticky", 32'(err_o), 32'd1);
        chk("mr a_rdata untouched", 32'(a_rdata_o), 32'd0);
        do_reset("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
